redundancy_pair_scanner: RTL and testbench
==========================================

// Module: redundancy_pair_scanner
// PURPOSE
//  Upstream feeder of the distance calculator. Buffers one lowered filter row (weights), scans it for
//  equal-valued weight pairs and emits each pair as (idx1 < idx2) over a valid/ready handshake.
//  For each idx1, only the nearest later duplicate idx2 is emitted. Runs one compare per cycle.
// PARAMETERS
//  WORD_WIDTH  8    width of weights, indices and length
//  MAX_W_SIZE  128  buffer depth; max row length (must be <= 2**WORD_WIDTH)
// PORTS
//  clk         in   1           single clock; all state changes on rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  start       in   1           begin a row; sampled only in IDLE
//  len         in   WORD_WIDTH  row length, sampled with start (0..MAX_W_SIZE)
//  w_valid     in   1           weight write valid
//  w_ready     out  1           weight write ready (LOAD state only)
//  w_data      in   WORD_WIDTH  weight value
//  pair_valid  out  1           pair available
//  pair_ready  in   1           consumer accepts pair
//  idx1        out  WORD_WIDTH  smaller index of pair
//  idx2        out  WORD_WIDTH  larger index of pair
//  busy        out  1           high in every state except IDLE
//  done        out  1           one-cycle pulse when scan of row completes
//  pair_count  out  WORD_WIDTH  pairs emitted for current row; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; w_ready, pair_valid, busy, done=0; idx1, idx2, pair_count, counters=0.
//  FSM IDLE->LOAD->SCAN<->EMIT->DONE->IDLE.
//  IDLE: start=1 latches len, wr_ptr=0, pair_count=0; len==0 or len==1 -> DONE, else -> LOAD.
//  LOAD: w_ready=1; each w_valid&w_ready writes buf[wr_ptr], wr_ptr++. Write at wr_ptr==len-1 ->
//    SCAN with i=0, j=1 next cycle. Idle cycles (w_valid=0) allowed.
//  SCAN: compares buf[i]==buf[j] once per cycle. Match -> EMIT; idx1=i, idx2=j registered.
//    No match, j<len-1 -> j++. No match, j==len-1 -> ADVANCE.
//  EMIT: pair_valid=1; idx1/idx2 held stable until pair_ready. On handshake pair_count++ (saturates
//    at all-ones), then ADVANCE. No new compare while pair_valid is high.
//  ADVANCE rule: if i+1 >= len-1 -> DONE; else i=i+1, j=i+2.
//  DONE: done=1 for exactly one cycle, busy=1 in that cycle, -> IDLE.
//  Last index (len-1) is never idx1. Duplicates chain: weights {5,5,5} -> (0,1),(1,2).
//  start outside IDLE is ignored; len > MAX_W_SIZE is clamped to MAX_W_SIZE.
//  Latency: first compare 1 cycle after last write; worst case ~len*(len-1)/2 SCAN cycles
//    plus stall cycles.
//  Reset asserted mid-operation: immediate return to reset values; buffer contents undefined,
//    never read until reloaded.
// CONFIGURATION
//  SKIP_ZERO_EN defined: a weight equal to 0 never forms a pair.
//    - buf[i]==0 -> ADVANCE in the same cycle without scanning j.
//    - A buf[j]==0 candidate never matches.
//  SKIP_ZERO_EN undefined: zeros are compared like any other value.
// STRUCTURE
//  Shared package rc_pkg: FSM state encoding (IDLE, LOAD, SCAN, EMIT, DONE), WORD_WIDTH/MAX_W_SIZE
//    defaults, index type. The same package is used by the distance calculator.
//  Sub-module rc_weight_buffer: MAX_W_SIZE x WORD_WIDTH register file.
//    - One write port.
//    - Two combinational read ports (i, j); no reset on storage.
//  Top holds FSM, i/j/wr_ptr counters, output registers.
// TESTING
//  1. Reset mid-LOAD: start len=4, write 2 words, reset_n=0 -> all outputs 0, IDLE, busy=0.
//  2. len=4 {3,7,3,7}, pair_ready=1 -> pairs (0,2),(1,3); pair_count=2; done pulse once.
//  3. len=3 {5,5,5}, pair_ready low 3 cycles on first pair -> idx1=0, idx2=1 stable while stalled;
//     then pair (1,2); pair_count=2.
//  4. len=5 {1,2,3,4,9} -> no pair_valid; done after 10 SCAN cycles; pair_count=0.
//  5. len=1, and separately len=0 -> no write accepted; done 1 cycle after start; start during
//     busy is ignored.
//  6. len=4 {0,0,6,6}: SKIP_ZERO_EN -> only (2,3); without the macro -> (0,1),(2,3).

Source files
------------

// File: rtl/rc_pkg.sv
// rc_pkg: state encoding, default sizes and index type shared by the scanner and the distance calculator
package rc_pkg;
  localparam int RC_WORD_WIDTH = 8;
  localparam int RC_MAX_W_SIZE = 128;
  typedef enum logic [2:0] {RC_IDLE, RC_LOAD, RC_SCAN, RC_EMIT, RC_DONE} rc_state_e;
  typedef logic [RC_WORD_WIDTH-1:0] rc_idx_t;
endpackage

// File: rtl/rc_weight_buffer.sv
// rc_weight_buffer: weight row storage, one write port and two combinational read ports, storage not reset
module rc_weight_buffer #(
  parameter int WORD_WIDTH = 8,
  parameter int MAX_W_SIZE = 128,
  parameter int AW = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr_i,
  input  logic [AW-1:0]         i_raddr_j,
  output logic [WORD_WIDTH-1:0] o_rdata_i,
  output logic [WORD_WIDTH-1:0] o_rdata_j
);
  logic [WORD_WIDTH-1:0] r_mem [MAX_W_SIZE];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata_i = r_mem[i_raddr_i];
  assign o_rdata_j = r_mem[i_raddr_j];
endmodule

// File: rtl/redundancy_pair_scanner.sv
// redundancy_pair_scanner: buffers a weight row and emits (i, nearest later duplicate j) pairs.
// Optional build macro SKIP_ZERO_EN: zero-valued weights never form a pair.
module redundancy_pair_scanner
  import rc_pkg::*;
#(
  parameter int WORD_WIDTH = RC_WORD_WIDTH,
  parameter int MAX_W_SIZE = RC_MAX_W_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] len,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [WORD_WIDTH-1:0] w_data,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [WORD_WIDTH-1:0] idx1,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] pair_count
);
  localparam int AW = (MAX_W_SIZE > 1) ? $clog2(MAX_W_SIZE) : 1;
  rc_state_e r_state;
  logic [WORD_WIDTH-1:0] r_len, r_wr_ptr, r_i, r_j;
  logic [WORD_WIDTH-1:0] w_len_clamp, w_wi, w_wj;
  logic w_match, w_skip, w_last_i, w_j_end;
  rc_weight_buffer #(.WORD_WIDTH(WORD_WIDTH), .MAX_W_SIZE(MAX_W_SIZE), .AW(AW)) u_buf (
    .clk       (clk),
    .i_we      (w_ready & w_valid),
    .i_waddr   (r_wr_ptr[AW-1:0]),
    .i_wdata   (w_data),
    .i_raddr_i (r_i[AW-1:0]),
    .i_raddr_j (r_j[AW-1:0]),
    .o_rdata_i (w_wi),
    .o_rdata_j (w_wj)
  );
  assign w_len_clamp = (int'(len) > MAX_W_SIZE) ? WORD_WIDTH'(MAX_W_SIZE) : len;
`ifdef SKIP_ZERO_EN
  assign w_skip  = (w_wi == '0);
  assign w_match = (w_wi == w_wj) && (w_wj != '0);
`else
  assign w_skip  = 1'b0;
  assign w_match = (w_wi == w_wj);
`endif
  // row scan ends once i reaches the second-to-last index
  assign w_last_i = (r_i + 1'b1) >= (r_len - 1'b1);
  assign w_j_end  = (r_j == r_len - 1'b1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RC_IDLE;
      r_len      <= '0;
      r_wr_ptr   <= '0;
      r_i        <= '0;
      r_j        <= '0;
      w_ready    <= 1'b0;
      pair_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx1       <= '0;
      idx2       <= '0;
      pair_count <= '0;
    end else begin
      case (r_state)
        RC_IDLE: if (start) begin
          r_len      <= w_len_clamp;
          r_wr_ptr   <= '0;
          pair_count <= '0;
          busy       <= 1'b1;
          if (w_len_clamp < WORD_WIDTH'(2)) begin
            r_state <= RC_DONE;
            done    <= 1'b1;
          end else begin
            r_state <= RC_LOAD;
            w_ready <= 1'b1;
          end
        end
        RC_LOAD: if (w_valid) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_wr_ptr == r_len - 1'b1) begin
            r_state <= RC_SCAN;
            w_ready <= 1'b0;
            r_i     <= '0;
            r_j     <= WORD_WIDTH'(1);
          end
        end
        RC_SCAN: begin
          if (w_match && !w_skip) begin
            r_state    <= RC_EMIT;
            pair_valid <= 1'b1;
            idx1       <= r_i;
            idx2       <= r_j;
          end else if (!w_skip && !w_j_end) begin
            r_j <= r_j + 1'b1;
          end else if (w_last_i) begin
            r_state <= RC_DONE;
            done    <= 1'b1;
          end else begin
            r_i <= r_i + 1'b1;
            r_j <= r_i + 2'd2;
          end
        end
        RC_EMIT: if (pair_ready) begin
          pair_valid <= 1'b0;
          if (pair_count != '1) pair_count <= pair_count + 1'b1;
          if (w_last_i) begin
            r_state <= RC_DONE;
            done    <= 1'b1;
          end else begin
            r_state <= RC_SCAN;
            r_i     <= r_i + 1'b1;
            r_j     <= r_i + 2'd2;
          end
        end
        RC_DONE: begin
          r_state <= RC_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= RC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_redundancy_pair_scanner.sv
// tb_redundancy_pair_scanner: scoreboard bench; expected pairs queued at load time, checked on handshake
module tb_redundancy_pair_scanner;
  logic clk = 0, reset_n = 0, start = 0, w_valid = 0, pair_ready = 1;
  logic [7:0] len = 0, w_data = 0;
  logic w_ready, pair_valid, busy, done;
  logic [7:0] idx1, idx2, pair_count;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, stall_n = 0;
  logic [15:0] exp_q[$];
  logic [7:0] row[$];

  redundancy_pair_scanner dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .idx1(idx1), .idx2(idx2),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pair_valid && stall_n > 0) begin
      pair_ready = 0;
      stall_n--;
    end else pair_ready = 1;
  endtask

  always @(negedge clk) if (reset_n) begin
    if (done) done_cnt <= done_cnt + 1;
    if (pair_valid) begin
      check("pair_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check(pair_ready ? "pair" : "hold", {idx1, idx2}, exp_q[0]);
        if (pair_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit wmatch(input logic [7:0] a, input logic [7:0] b);
`ifdef SKIP_ZERO_EN
    return a == b && a != 0;
`else
    return a == b;
`endif
  endfunction

  task automatic run_row(input int l, input int stalls, input int exp_scan, input bit poke);
    int le, np, cw, d0, guard;
    le = l > 128 ? 128 : l;
    np = 0;
    for (int i = 0; i < le - 1; i++)
      for (int j = i + 1; j < le; j++)
        if (wmatch(row[i], row[j])) begin
          exp_q.push_back({8'(i), 8'(j)});
          np++;
          break;
        end
    stall_n = stalls;
    d0 = done_cnt;
    start = 1;
    len = 8'(l);
    tick();
    start = 0;
    check("busy", busy, 1);
    cw = cyc;
    if (le < 2) begin
      check("done_fast", done, 1);
      check("no_w_ready", w_ready, 0);
    end else begin
      for (int k = 0; k < le; k++) begin
        if (k == 1) begin
          w_valid = 0;
          tick();
        end
        if (poke && k == 2) begin
          start = 1;
          len = 0;
        end
        w_valid = 1;
        w_data = row[k];
        check("w_ready", w_ready, 1);
        tick();
        start = 0;
      end
      w_valid = 0;
      cw = cyc;
      check("w_ready_off", w_ready, 0);
    end
    guard = 0;
    while (!done && guard < 20000) begin
      tick();
      guard++;
    end
    check("done_seen", done, 1);
    if (exp_scan >= 0) check("scan_cycles", cyc - cw, exp_scan);
    check("pair_count", pair_count, np);
    repeat (3) tick();
    check("done_pulses", done_cnt - d0, 1);
    check("idle", busy, 0);
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_pcount", pair_count, 0);
    reset_n = 1;
    tick();
    start = 1;
    len = 4;
    tick();
    start = 0;
    w_valid = 1;
    w_data = 9;
    repeat (2) tick();
    w_valid = 0;
    reset_n = 0;
    #1;
    check("mid_rst_outs", {w_ready, pair_valid, busy, done, idx1, idx2, pair_count}, 0);
    tick();
    reset_n = 1;
    tick();
    check("after_rst_idle", {busy, w_ready}, 0);

    row = '{3, 7, 3, 7};       run_row(4, 0, -1, 1);
    row = '{5, 5, 5};          run_row(3, 3, -1, 0);
    row = '{1, 2, 3, 4, 9};    run_row(5, 0, 10, 0);
    row = {};                  run_row(1, 0, -1, 0);
    row = {};                  run_row(0, 0, -1, 0);
    row = '{0, 0, 6, 6};       run_row(4, 0, -1, 0);
    for (int r = 0; r < 3; r++) begin
      row = {};
      for (int k = 0; k < 8; k++) row.push_back(8'($urandom_range(0, 3)));
      run_row(8, 2, -1, 0);
    end
    row = {};
    for (int k = 0; k < 128; k++) row.push_back(8'(k));
    run_row(200, 0, 8128, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
